// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
// Opcodes are 4 bits wide so encodings 8..15 exist and are flagged as illegal.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DIVWAIT,
        OUT
    } exec_state_t;

endpackage

// File: rtl/instr_divider.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle.
// The launch edge already performs the first step, so done pulses DIV_ITER-1 cycles after the launch edge.
module instr_divider
    import instr_register_pkg::*;
#(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     start,
    input  operand_t dividend,
    input  operand_t divisor,
    output result_t  quotient,
    output result_t  remainder,
    output logic     done
);

    localparam int unsigned CNT_W = $clog2(DIV_ITER + 1);

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_acc_t;

    function automatic logic [31:0] magnitude(input operand_t v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic result_t apply_sign(input logic neg, input logic [31:0] mag);
        result_t v;
        v = result_t'({32'b0, mag});
        return neg ? -v : v;
    endfunction

    div_acc_t          acc;
    div_acc_t          step_in;
    div_acc_t          step_out;
    logic [31:0]       dmag;
    logic [31:0]       step_dmag;
    logic [32:0]       trial;
    logic              q_neg;
    logic              r_neg;
    logic              running;
    logic [CNT_W-1:0]  cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step_in   = running ? acc : '{rem: '0, quo: magnitude(dividend)};
        step_dmag = running ? dmag : magnitude(divisor);
        trial     = {step_in.rem, step_in.quo[31]};
        step_out  = '{rem: trial[31:0], quo: {step_in.quo[30:0], 1'b0}};
        if (trial >= {1'b0, step_dmag}) begin
            step_out.rem = 32'(trial - {1'b0, step_dmag});
            step_out.quo = {step_in.quo[30:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            dmag      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            running   <= 1'b0;
            cnt       <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start && !running) begin
                acc     <= step_out;
                dmag    <= step_dmag;
                q_neg   <= dividend[31] ^ divisor[31];
                r_neg   <= dividend[31];
                cnt     <= CNT_W'(DIV_ITER - 1);
                running <= 1'b1;
            end else if (running) begin
                acc <= step_out;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running   <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= apply_sign(q_neg, step_out.quo);
                    remainder <= apply_sign(r_neg, step_out.rem);
                end
            end
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a range of instruction-register entries, evaluates each
// opcode and streams one 64-bit result per entry over a valid/ready handshake.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned DIV_ITER    = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      res_data,
    output address_t     res_addr,
    output logic         res_err,
    output logic         busy,
    output logic         done
);

    exec_state_t  state, state_next;
    instruction_t instr_q;
    address_t     addr;
    logic [5:0]   remaining;
    result_t      op_a, op_b;
    result_t      exec_data;
    logic         exec_err;
    logic         handshake, last, is_div, div_start, div_done;
    result_t      div_quo, div_rem;

    assign op_a         = result_t'(instr_q.op_a);
    assign op_b         = result_t'(instr_q.op_b);
    assign handshake    = (state == OUT) && res_ready;
    assign last         = (remaining == 6'd1);
    assign is_div       = instr_q.opc inside {DIV, MOD};
    assign div_start    = (state == EXEC) && is_div && (instr_q.op_b != '0);
    assign read_pointer = addr;
    assign res_valid    = (state == OUT);
    assign busy         = (state != IDLE);

    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        case (instr_q.opc)
            ZERO:     exec_data = '0;
            PASSA:    exec_data = op_a;
            PASSB:    exec_data = op_b;
            ADD:      exec_data = op_a + op_b;
            SUB:      exec_data = op_a - op_b;
            MULT:     exec_data = op_a * op_b;
            DIV, MOD: exec_err  = (instr_q.op_b == '0);
            default:  exec_err  = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && count != 6'd0) state_next = FETCH;
            FETCH:   state_next = EXEC;
            EXEC:    state_next = div_start ? DIVWAIT : OUT;
            DIVWAIT: if (div_done) state_next = OUT;
            OUT:     if (handshake) state_next = last ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            instr_q   <= '0;
            res_data  <= '0;
            res_addr  <= '0;
            res_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= ((state == IDLE) && start && (count == 6'd0)) || (handshake && last);
            case (state)
                IDLE: begin
                    if (start && count != 6'd0) begin
                        addr      <= start_addr;
                        remaining <= count;
                    end
                end
                FETCH: instr_q <= instruction_word;
                EXEC: begin
                    res_addr <= addr;
                    if (!div_start) begin
                        res_data <= exec_data;
                        res_err  <= exec_err;
                    end
                end
                DIVWAIT: begin
                    if (div_done) begin
                        res_data <= (instr_q.opc == MOD) ? div_rem : div_quo;
                        res_err  <= 1'b0;
                    end
                end
                OUT: begin
                    if (handshake) begin
                        remaining <= remaining - 6'd1;
                        if (!last)
                            addr <= (addr == address_t'(NUM_ENTRIES - 1)) ? '0 : addr + address_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    instr_divider #(
        .DIV_ITER(DIV_ITER)
    ) u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (instr_q.op_a),
        .divisor  (instr_q.op_b),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: a behavioural instruction register feeds the
// DUT and each result, latency and handshake is compared with hand-computed values.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    address_t     start_addr = '0;
    logic [5:0]   count = '0;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready = 1'b1;
    result_t      res_data;
    address_t     res_addr;
    logic         res_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .start_addr      (start_addr),
        .count           (count),
        .read_pointer    (read_pointer),
        .instruction_word(instruction_word),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_addr        (res_addr),
        .res_err         (res_err),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string tag, input result_t got, input result_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t r;
        r.opc  = o;
        r.op_a = a;
        r.op_b = b;
        return r;
    endfunction

    // Returns at the negedge of the first cycle after the start-sampling edge T.
    task automatic start_cmd(input address_t a, input logic [5:0] c);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        count      = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc tracks the cycle index after T; called at some cycle's negedge.
    task automatic wait_valid(input int from_cyc, input int limit, output int cyc);
        cyc = from_cyc;
        while (!res_valid && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_one(input string tag, input address_t a, input result_t exp_d,
                           input logic exp_e, input int exp_cyc);
        int cyc;
        start_cmd(a, 6'd1);
        wait_valid(1, 60, cyc);
        check({tag, " latency"}, result_t'(cyc), result_t'(exp_cyc));
        check({tag, " data"}, res_data, exp_d);
        check({tag, " err"}, result_t'(res_err), result_t'(exp_e));
        check({tag, " addr"}, result_t'(res_addr), result_t'(a));
        @(negedge clk);
        check({tag, " done"}, result_t'({done, busy}), result_t'(2'b10));
    endtask

    initial begin
        int cyc;
        int stray;
        for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0);
        mem[0]  = mk(ADD, 5, 7);
        mem[1]  = mk(SUB, 3, 10);
        mem[2]  = mk(MULT, -4, 6);
        mem[4]  = mk(DIV, -7, 2);
        mem[5]  = mk(MOD, -7, 2);
        mem[6]  = mk(DIV, 10, 0);
        mem[7]  = mk(MULT, 32'sh7FFFFFFF, 32'sh7FFFFFFF);
        mem[8]  = mk(DIV, 32'sh80000000, -1);
        mem[9]  = mk(opcode_t'(4'hF), 3, 4);
        mem[10] = mk(PASSB, 1, -9);
        mem[31] = mk(ADD, 1, 2);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst valid", result_t'(res_valid), 0);
        check("rst outs", result_t'({read_pointer, res_addr, res_err, busy, done}), 0);
        check("rst data", res_data, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-rst busy", result_t'({busy, res_valid, done}), 0);

        // Basic three-entry sequence with res_ready high
        start_cmd(5'd0, 6'd3);
        check("seq busy", result_t'(busy), 1);
        wait_valid(1, 20, cyc);
        check("seq latency", result_t'(cyc), 3);
        check("seq r0", res_data, 12);
        check("seq a0", result_t'(res_addr), 0);
        @(negedge clk);
        wait_valid(cyc + 1, 30, cyc);
        check("seq r1", res_data, -7);
        check("seq a1", result_t'(res_addr), 1);
        check("seq r1 cyc", result_t'(cyc), 6);
        @(negedge clk);
        wait_valid(cyc + 1, 30, cyc);
        check("seq r2", res_data, -24);
        check("seq a2", result_t'(res_addr), 2);
        @(negedge clk);
        check("seq done", result_t'({done, busy}), result_t'(2'b10));
        @(negedge clk);
        check("seq done pulse", result_t'(done), 0);

        // Division, errors and extremes
        run_one("div", 5'd4, -3, 1'b0, 35);
        run_one("mod", 5'd5, -1, 1'b0, 35);
        run_one("div0", 5'd6, 0, 1'b1, 3);
        run_one("mulmax", 5'd7, 64'sh3FFFFFFF00000001, 1'b0, 3);
        run_one("divmin", 5'd8, 64'sh0000000080000000, 1'b0, 35);
        run_one("illegal", 5'd9, 0, 1'b1, 3);
        run_one("passb", 5'd10, -9, 1'b0, 3);

        // Backpressure and address wrap
        res_ready = 1'b0;
        start_cmd(5'd31, 6'd2);
        check("wrap rp0", result_t'(read_pointer), 31);
        wait_valid(1, 20, cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp valid", result_t'(res_valid), 1);
            check("bp data", res_data, 3);
        end
        check("bp addr", result_t'(res_addr), 31);
        res_ready = 1'b1;
        @(negedge clk);
        check("wrap rp1", result_t'(read_pointer), 0);
        wait_valid(1, 20, cyc);
        check("wrap data", res_data, 12);
        check("wrap addr", result_t'(res_addr), 0);
        @(negedge clk);
        check("wrap done", result_t'({done, busy}), result_t'(2'b10));

        // start while busy is ignored
        start_cmd(5'd0, 6'd1);
        start = 1'b1; start_addr = 5'd5; count = 6'd3;
        @(negedge clk);
        start = 1'b0;
        wait_valid(2, 20, cyc);
        check("ign data", res_data, 12);
        check("ign addr", result_t'(res_addr), 0);
        @(negedge clk);
        check("ign done", result_t'({done, busy}), result_t'(2'b10));
        repeat (3) @(negedge clk);
        check("ign idle", result_t'({busy, res_valid}), 0);

        // count = 0
        start_cmd(5'd3, 6'd0);
        check("cnt0 done", result_t'({done, busy, res_valid}), result_t'(3'b100));
        @(negedge clk);
        check("cnt0 quiet", result_t'({done, busy, res_valid}), 0);

        // Reset during DIVWAIT
        start_cmd(5'd4, 6'd1);
        repeat (10) @(negedge clk);
        check("abort busy", result_t'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort outs", result_t'({busy, res_valid, done, res_err, read_pointer, res_addr}), 0);
        check("abort data", res_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid || busy) stray++;
        end
        check("abort no result", result_t'(stray), 0);
        run_one("recover", 5'd5, -1, 1'b0, 35);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
